// File: rtl/mem_map_pkg.sv
// Shared bus encodings and memory map for the CPU and mem_io_ctrl.
// Timer addresses are only decoded when MEM_IO_TIMER_EN is defined.
package mem_map_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LED_ADDR    = 9'h100;
  localparam logic [8:0] SW_ADDR     = 9'h140;
  localparam logic [8:0] TCOUNT_ADDR = 9'h180;
  localparam logic [8:0] TCTRL_ADDR  = 9'h181;

  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_e;

  function automatic logic is_ram_addr(input logic [8:0] addr);
    return ~addr[8];
  endfunction

endpackage

// File: rtl/io_timer.sv
// Free-running 16-bit timer with enable and sticky wrap flag.
// Instantiated by mem_io_ctrl only when MEM_IO_TIMER_EN is defined.
module io_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        ctrl_we,
  input  logic [15:0] write_data,
  output logic [15:0] count,
  output logic        en,
  output logic        wrap
);

  logic [15:0] count_q, count_d;
  logic        en_q, en_d;
  logic        wrap_q, wrap_d;
  logic        wrap_set;

  always_comb begin
    count_d  = count_q;
    en_d     = en_q;
    wrap_set = 1'b0;
    if (count_we) begin
      count_d = write_data;
    end else if (en_q) begin
      count_d  = count_q + 16'd1;
      wrap_set = (count_q == 16'hFFFF);
    end
    if (ctrl_we) begin
      en_d = write_data[0];
    end
    // A wrap in the same cycle as a clear wins.
    wrap_d = wrap_set | (wrap_q & ~(ctrl_we & write_data[1]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign en    = en_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/I-O bus controller: RAM write enable, LED, switch sync, 1-cycle read return.
// Optional timer at TCOUNT/TCTRL enabled by defining MEM_IO_TIMER_EN.
module mem_io_ctrl
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        ram_we,
  input  logic [15:0] ram_dout,
  input  logic [9:0]  sw,
  output logic [7:0]  led
);

  logic        is_write, is_read;
  logic [7:0]  led_q, led_d;
  logic [9:0]  sw_meta_q, sw_sync_q;
  rd_src_e     rd_src_q, rd_src_d;
  logic [15:0] rd_word_q, rd_word_d;
  logic [15:0] io_word;

  assign is_write = (mem_cmd == MWRITE);
  assign is_read  = (mem_cmd == MREAD);
  assign ram_we   = is_write & is_ram_addr(mem_addr);

`ifdef MEM_IO_TIMER_EN
  logic [15:0] tmr_count;
  logic        tmr_en, tmr_wrap;

  io_timer u_io_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (is_write && (mem_addr == TCOUNT_ADDR)),
    .ctrl_we    (is_write && (mem_addr == TCTRL_ADDR)),
    .write_data (write_data),
    .count      (tmr_count),
    .en         (tmr_en),
    .wrap       (tmr_wrap)
  );
`else
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^write_data[15:8];
`endif

  // RAM addresses fall through to 0 here; their data comes from ram_dout.
  always_comb begin
    io_word = '0;
    case (mem_addr)
      LED_ADDR:    io_word = {8'h00, led_q};
      SW_ADDR:     io_word = {6'b0, sw_sync_q};
`ifdef MEM_IO_TIMER_EN
      TCOUNT_ADDR: io_word = tmr_count;
      TCTRL_ADDR:  io_word = {14'b0, tmr_wrap, tmr_en};
`endif
      default:     io_word = '0;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    rd_src_d  = rd_src_q;
    rd_word_d = rd_word_q;
    if (is_write && (mem_addr == LED_ADDR)) begin
      led_d = write_data[7:0];
    end
    if (is_read) begin
      rd_src_d  = is_ram_addr(mem_addr) ? SRC_RAM : SRC_IO;
      rd_word_d = io_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rd_src_q  <= SRC_IO;
      rd_word_q <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      rd_src_q  <= rd_src_d;
      rd_word_q <= rd_word_d;
    end
  end

  assign read_data = (rd_src_q == SRC_RAM) ? ram_dout : rd_word_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with a read-return scoreboard and a sync RAM model.
// Timer checks run when MEM_IO_TIMER_EN is defined, unmapped-timer checks otherwise.
module tb_mem_io_ctrl;
  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [9:0]  sw;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ram_model [0:255];

  mem_io_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .sw         (sw),
    .led        (led)
  );

  always #5 clk = ~clk;

  // Synchronous RAM addressed directly by mem_addr.
  always @(posedge clk) begin
    if (ram_we) ram_model[mem_addr[7:0]] <= write_data;
    ram_dout <= ram_model[mem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check ram_we, cross the edge, then retire any read.
  task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data,
                     input logic [15:0] exp_rd, input logic exp_we);
    logic        did_read;
    logic [15:0] exp;
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    did_read   = (cmd == MREAD);
    if (did_read) exp_q.push_back(exp_rd);
    #1;
    check("ram_we", {15'b0, ram_we}, {15'b0, exp_we});
    @(posedge clk);
    #1;
    mem_cmd = MNONE;
    if (did_read) begin
      exp = exp_q.pop_front();
      check("read_data", read_data, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    mem_cmd    = MNONE;
    mem_addr   = '0;
    write_data = '0;
    sw         = '0;
    #2;
    check("rst_read_data", read_data, 16'h0000);
    check("rst_led", {8'h00, led}, 16'h0000);
    check("rst_ram_we", {15'b0, ram_we}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // RAM path
    bus(MWRITE, 9'h005, 16'hBEEF, 16'h0, 1'b1);
    bus(MREAD,  9'h005, 16'h0000, 16'hBEEF, 1'b0);
    bus(MWRITE, 9'h0FF, 16'h1357, 16'h0, 1'b1);
    bus(MREAD,  9'h0FF, 16'h0000, 16'h1357, 1'b0);

    // LED, unmapped neighbour, reserved command, read hold
    bus(MWRITE, LED_ADDR, 16'h12A5, 16'h0, 1'b0);
    check("led_write", {8'h00, led}, 16'h00A5);
    bus(MREAD,  LED_ADDR, 16'h0000, 16'h00A5, 1'b0);
    bus(MWRITE, 9'h101, 16'hFFFF, 16'h0, 1'b0);
    check("led_unmapped_write", {8'h00, led}, 16'h00A5);
    bus(MREAD,  9'h101, 16'h0000, 16'h0000, 1'b0);
    bus(MREAD,  LED_ADDR, 16'h0000, 16'h00A5, 1'b0);
    bus(2'b11,  LED_ADDR, 16'h0055, 16'h0, 1'b0);
    check("cmd11_led", {8'h00, led}, 16'h00A5);
    check("read_hold", read_data, 16'h00A5);
    bus(2'b11,  9'h005, 16'h0000, 16'h0, 1'b0);

    // Switch synchronizer latency
    sw = 10'h3FF;
    bus(MNONE, 9'h000, 16'h0000, 16'h0, 1'b0);
    bus(MREAD, SW_ADDR, 16'h0000, 16'h0000, 1'b0);
    bus(MREAD, SW_ADDR, 16'h0000, 16'h03FF, 1'b0);

    // Back-to-back reads across regions
    bus(MREAD, LED_ADDR, 16'h0000, 16'h00A5, 1'b0);
    bus(MREAD, 9'h005,   16'h0000, 16'hBEEF, 1'b0);
    bus(MREAD, SW_ADDR,  16'h0000, 16'h03FF, 1'b0);

`ifdef MEM_IO_TIMER_EN
    bus(MREAD,  TCOUNT_ADDR, 16'h0000, 16'h0000, 1'b0);
    bus(MWRITE, TCOUNT_ADDR, 16'hFFFE, 16'h0, 1'b0);
    bus(MWRITE, TCTRL_ADDR,  16'h0001, 16'h0, 1'b0);
    bus(MNONE,  9'h000, 16'h0000, 16'h0, 1'b0);
    bus(MNONE,  9'h000, 16'h0000, 16'h0, 1'b0);
    bus(MREAD,  TCTRL_ADDR,  16'h0000, 16'h0003, 1'b0);
    bus(MREAD,  TCOUNT_ADDR, 16'h0000, 16'h0001, 1'b0);
    bus(MWRITE, TCTRL_ADDR,  16'h0003, 16'h0, 1'b0);
    bus(MREAD,  TCTRL_ADDR,  16'h0000, 16'h0001, 1'b0);
    bus(MWRITE, TCOUNT_ADDR, 16'hFFFE, 16'h0, 1'b0);
    bus(MNONE,  9'h000, 16'h0000, 16'h0, 1'b0);
    bus(MWRITE, TCTRL_ADDR,  16'h0003, 16'h0, 1'b0);
    bus(MREAD,  TCTRL_ADDR,  16'h0000, 16'h0003, 1'b0);
    bus(MREAD,  TCOUNT_ADDR, 16'h0000, 16'h0001, 1'b0);
    bus(MWRITE, TCTRL_ADDR,  16'h0000, 16'h0, 1'b0);
    bus(MREAD,  TCOUNT_ADDR, 16'h0000, 16'h0003, 1'b0);
    bus(MREAD,  TCOUNT_ADDR, 16'h0000, 16'h0003, 1'b0);
    bus(MREAD,  TCTRL_ADDR,  16'h0000, 16'h0002, 1'b0);
`else
    bus(MWRITE, TCOUNT_ADDR, 16'h1234, 16'h0, 1'b0);
    bus(MREAD,  TCOUNT_ADDR, 16'h0000, 16'h0000, 1'b0);
    bus(MWRITE, TCTRL_ADDR,  16'h0003, 16'h0, 1'b0);
    bus(MREAD,  TCTRL_ADDR,  16'h0000, 16'h0000, 1'b0);
`endif

    // Asynchronous reset with a read pending
    bus(MWRITE, LED_ADDR, 16'h00FF, 16'h0, 1'b0);
    bus(MREAD,  LED_ADDR, 16'h0000, 16'h00FF, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_led", {8'h00, led}, 16'h0000);
    check("async_rst_read_data", read_data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus(MREAD, TCTRL_ADDR, 16'h0000, 16'h0000, 1'b0);
    bus(MREAD, LED_ADDR,   16'h0000, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
